// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read, captured into IR and handed
// to control through a valid/take handshake; flags misaligned PCs and memory timeouts.
module instr_fetch_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_take,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              busy
);

  localparam int                TMR_W          = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST       = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] NOP_INSN       = DATA_W'(32'h0000_0013);
  localparam logic [1:0]        CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]        CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               rden_q, rden_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic               irv_q, irv_d;
  logic               fault_q, fault_d;
  logic [1:0]         cause_q, cause_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               issue_s;

  // Next-state logic; a fetch can start from IDLE or, back-to-back, from FULL on take
  always_comb begin
    state_d = state_q;
    rden_d  = rden_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    fault_d = 1'b0;
    cause_d = cause_q;
    timer_d = timer_q;
    issue_s = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      rden_d  = 1'b0;
      irv_d   = 1'b0;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          issue_s = fetch_req;
        end
        S_WAIT: begin
          if (mem_ack) begin
            ir_d    = mem_dout;
            irv_d   = 1'b1;
            rden_d  = 1'b0;
            state_d = S_FULL;
          end else if (timer_q == TMR_LAST) begin
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
            rden_d  = 1'b0;
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_FULL: begin
          if (ir_take) begin
            irv_d   = 1'b0;
            state_d = S_IDLE;
            issue_s = fetch_req;
          end else begin
            irv_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          rden_d  = 1'b0;
          irv_d   = 1'b0;
          timer_d = '0;
        end
      endcase
      if (issue_s) begin
        if (pc_addr[1:0] != 2'b00) begin
          fault_d = 1'b1;
          cause_d = CAUSE_MISALIGN;
          state_d = S_IDLE;
        end else begin
          addr_d  = pc_addr;
          rden_d  = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end else begin
        issue_s = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      ir_q    <= NOP_INSN;
      irv_q   <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      timer_q <= timer_d;
    end
  end

  assign mem_rden    = rden_q;
  assign mem_addr    = addr_q;
  assign ir          = ir_q;
  assign ir_valid    = irv_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign busy        = (state_q != S_IDLE);

endmodule
